// File: rtl/mem_port_if.sv
// -----------------------------------------------------------------------------
// mem_port_if
//   Handshake and control bundle between the CPU pipeline (IF / MEM stages and
//   hazard unit) and the unified-memory port arbiter.
//
//   Signals
//     i_req   fetch request, held until i_ack
//     d_req   data request, held until d_ack
//     d_we    data write enable, meaningful at grant only
//     sel     address/data mux select: 1 = data side, 0 = PC
//     mem_en  memory enable
//     mem_we  memory write enable
//     i_ack   one-cycle fetch completion pulse
//     d_ack   one-cycle data completion pulse
//     i_stall fetch stall request to the hazard unit
//     d_stall data stall request to the hazard unit
//     busy    arbiter is in the middle of an access
//
//   Modports
//     slave   arbiter side (takes requests, drives memory control and acks)
//     master  pipeline side (drives requests, observes acks and stalls)
// -----------------------------------------------------------------------------
interface mem_port_if;
    logic i_req;
    logic d_req;
    logic d_we;
    logic sel;
    logic mem_en;
    logic mem_we;
    logic i_ack;
    logic d_ack;
    logic i_stall;
    logic d_stall;
    logic busy;

    modport slave (
        input  i_req, d_req, d_we,
        output sel, mem_en, mem_we, i_ack, d_ack, i_stall, d_stall, busy
    );

    modport master (
        output i_req, d_req, d_we,
        input  sel, mem_en, mem_we, i_ack, d_ack, i_stall, d_stall, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-ported unified memory between instruction fetch and the
//   MEM stage. Arbitration happens only while idle; data wins because it
//   belongs to the older instruction. Each granted access holds mem_en for
//   MEM_LAT cycles, pulses the matching ack in the last of them, and is always
//   followed by one idle cycle before the next grant.
//
//   Parameters
//     MEM_LAT    memory latency in cycles (>= 1)
//     MAX_D_RUN  data grants tolerated back-to-back while a fetch waits
//                (only with the starvation guard built in)
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   mem_port_if.slave: requests in; sel, mem_en, mem_we, i_ack,
//           d_ack, busy registered out; i_stall, d_stall combinational out
//
//   Build option
//     STARVE_GUARD_EN  when defined, a fetch that has watched MAX_D_RUN data
//                      grants go by is granted ahead of a pending data request.
//                      Undefined: strict data priority.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LAT   = 2,
    parameter int MAX_D_RUN = 4
) (
    input  logic       clk,
    input  logic       rst,
    mem_port_if.slave  bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_cnt_nxt;
    logic             last_cycle;
    logic             grant_d;
    logic             grant_i;
    logic             force_i;

    logic sel_reg,    sel_nxt;
    logic mem_en_reg, mem_en_nxt;
    logic mem_we_reg, mem_we_nxt;
    logic i_ack_reg,  i_ack_nxt;
    logic d_ack_reg,  d_ack_nxt;
    logic busy_reg,   busy_nxt;

    assign last_cycle = (lat_cnt == CNT_LAST);

`ifdef STARVE_GUARD_EN
    localparam int RUN_W = (MAX_D_RUN > 0) ? $clog2(MAX_D_RUN + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

    logic [RUN_W-1:0] d_run;
    logic [RUN_W-1:0] d_run_nxt;

    // A waiting fetch that has seen MAX_D_RUN data grants pass takes the port.
    assign force_i = bus.i_req && (d_run == RUN_MAX);

    // Run length counts only data grants that actually made a fetch wait;
    // it cannot pass RUN_MAX because force_i blocks that grant.
    always_comb begin
        d_run_nxt = d_run;
        if (grant_d) begin
            d_run_nxt = bus.i_req ? d_run + 1'b1 : '0;
        end else if (grant_i) begin
            d_run_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_run <= '0;
        end else begin
            d_run <= d_run_nxt;
        end
    end
`else
    localparam int unused_max_d_run = MAX_D_RUN;

    assign force_i = 1'b0;
`endif

    assign grant_d = (state == IDLE) && bus.d_req && !force_i;
    assign grant_i = (state == IDLE) && bus.i_req && !grant_d;

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            sel_reg    <= 1'b0;
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            i_ack_reg  <= 1'b0;
            d_ack_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            sel_reg    <= sel_nxt;
            mem_en_reg <= mem_en_nxt;
            mem_we_reg <= mem_we_nxt;
            i_ack_reg  <= i_ack_nxt;
            d_ack_reg  <= d_ack_nxt;
            busy_reg   <= busy_nxt;
        end
    end

    // Next state: arbitrate when idle, return to idle after the last access
    // cycle no matter what the requests are doing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = ACC_D;
                end else if (grant_i) begin
                    state_nxt = ACC_I;
                end
            end
            ACC_I, ACC_D: begin
                if (last_cycle) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, computed one cycle ahead so every memory-side output
    // leaves a flop and sel cannot glitch while mem_en is high.
    always_comb begin
        lat_cnt_nxt = '0;
        if ((state != IDLE) && !last_cycle) begin
            lat_cnt_nxt = lat_cnt + 1'b1;
        end

        sel_nxt    = (state_nxt == ACC_D);
        mem_en_nxt = (state_nxt != IDLE);
        busy_nxt   = (state_nxt != IDLE);

        // Write enable is captured at grant and held; later d_we edges are ignored.
        mem_we_nxt = 1'b0;
        if (grant_d) begin
            mem_we_nxt = bus.d_we;
        end else if ((state == ACC_D) && !last_cycle) begin
            mem_we_nxt = mem_we_reg;
        end

        // Ack lands in the final access cycle; for MEM_LAT=1 that is the first.
        i_ack_nxt = (state_nxt == ACC_I) && (lat_cnt_nxt == CNT_LAST);
        d_ack_nxt = (state_nxt == ACC_D) && (lat_cnt_nxt == CNT_LAST);
    end

    assign bus.sel     = sel_reg;
    assign bus.mem_en  = mem_en_reg;
    assign bus.mem_we  = mem_we_reg;
    assign bus.i_ack   = i_ack_reg;
    assign bus.d_ack   = d_ack_reg;
    assign bus.busy    = busy_reg;
    assign bus.i_stall = bus.i_req & ~i_ack_reg;
    assign bus.d_stall = bus.d_req & ~d_ack_reg;

endmodule
